// File: rtl/wb_queue_stage.sv
// wb_queue_stage: write-back select/format stage followed by a DEPTH-entry FIFO
// that drains into the register-file write port.
// Optional feature macro: WB_QUEUE_FWD_EN adds a forwarding search port
// (fwd_reg_i / fwd_hit_o / fwd_val_o) over the queued entries.
//
// Handshakes: input side transfers on in_valid_i & in_ready_o at a rising edge;
// the MEM stage must hold its inputs while in_ready_o is low. Output side
// transfers (pops) on wb_en_o & rf_ready_i at a rising edge; head outputs are
// held stable until popped. Both ready and valid depend only on registered state.
module wb_queue_stage #(
  parameter int DATA_W = 32,
  parameter int DEST_W = 4,
  parameter int DEPTH  = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic                       wb_en_i,
  input  logic                       mem_r_en_i,
  input  logic [1:0]                 ld_size_i,
  input  logic                       ld_signed_i,
  input  logic [1:0]                 ld_off_i,
  input  logic [DEST_W-1:0]          dest_i,
  input  logic [DATA_W-1:0]          alu_res_i,
  input  logic [DATA_W-1:0]          data_mem_i,
  output logic                       wb_en_o,
  input  logic                       rf_ready_i,
  output logic [DEST_W-1:0]          wb_dest_o,
  output logic [DATA_W-1:0]          wb_val_o,
`ifdef WB_QUEUE_FWD_EN
  input  logic [DEST_W-1:0]          fwd_reg_i,
  output logic                       fwd_hit_o,
  output logic [DATA_W-1:0]          fwd_val_o,
`endif
  output logic [$clog2(DEPTH):0]     level_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [DEST_W-1:0] dest_mem [DEPTH];
  logic [DATA_W-1:0] val_mem  [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [LVL_W-1:0]  level_q;

  logic              push;
  logic              pop;
  logic [31:0]       lane;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic [DATA_W-1:0] ld_val;
  logic [DATA_W-1:0] in_val;

  // Handshake qualifiers; ready comes from the level register only, so a pop
  // in the same cycle never makes room for a push while full.
  always_comb begin
    in_ready_o = (level_q != LVL_W'(DEPTH));
    wb_en_o    = (level_q != '0);
    push       = in_valid_i & in_ready_o & wb_en_i;
    pop        = wb_en_o & rf_ready_i;
  end

  // Load formatting: only the low 32-bit lane is addressed by ld_off_i.
  always_comb begin
    lane     = 32'(data_mem_i);
    byte_sel = lane[7:0];
    case (ld_off_i)
      2'd0: byte_sel = lane[7:0];
      2'd1: byte_sel = lane[15:8];
      2'd2: byte_sel = lane[23:16];
      default: byte_sel = lane[31:24];
    endcase
    half_sel = ld_off_i[1] ? lane[31:16] : lane[15:0];
    case (ld_size_i)
      2'b00:   ld_val = {{(DATA_W-8){ld_signed_i & byte_sel[7]}}, byte_sel};
      2'b01:   ld_val = {{(DATA_W-16){ld_signed_i & half_sel[15]}}, half_sel};
      default: ld_val = data_mem_i;
    endcase
    in_val = mem_r_en_i ? ld_val : alu_res_i;
  end

  // Head outputs forced to zero while the queue is empty.
  always_comb begin
    wb_dest_o = wb_en_o ? dest_mem[rd_ptr] : '0;
    wb_val_o  = wb_en_o ? val_mem[rd_ptr]  : '0;
    level_o   = level_q;
  end

  // FIFO storage, pointers and explicit occupancy counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      level_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        dest_mem[i] <= '0;
        val_mem[i]  <= '0;
      end
    end else begin
      if (push) begin
        dest_mem[wr_ptr] <= dest_i;
        val_mem[wr_ptr]  <= in_val;
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        level_q <= level_q + LVL_W'(1);
      end else if (pop && !push) begin
        level_q <= level_q - LVL_W'(1);
      end
    end
  end

`ifdef WB_QUEUE_FWD_EN
  logic [PTR_W-1:0] fwd_idx;

  // Forwarding search oldest to youngest so the youngest match wins; the
  // entry being popped still counts, the incoming push does not.
  always_comb begin
    fwd_hit_o = 1'b0;
    fwd_val_o = '0;
    fwd_idx   = rd_ptr;
    for (int k = 0; k < DEPTH; k++) begin
      fwd_idx = rd_ptr + PTR_W'(k);
      if ((LVL_W'(k) < level_q) && (dest_mem[fwd_idx] == fwd_reg_i)) begin
        fwd_hit_o = 1'b1;
        fwd_val_o = val_mem[fwd_idx];
      end
    end
  end
`endif

endmodule
